// File: rtl/cmi_decoder.sv
// rtl/cmi_decoder.sv - CMI chip-pair decoder with alignment hunt, lock and error tracking
module cmi_decoder #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk_sig,
    input  logic       reset_sig,
    input  logic       chip_valid_sig,
    input  logic       serial_encode_sig,
    output logic       decode_sig,
    output logic       decode_valid_sig,
    output logic [1:0] parallel_encode_sig,
    output logic       lock_sig,
    output logic       cv_err_sig,
    output logic       ar_err_sig
);

    // Counters share one width, wide enough for either threshold.
    localparam int CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             phase, phase_n;
    logic             first_chip, first_chip_n;
    logic [CNT_W-1:0] good_cnt, good_cnt_n;
    logic [CNT_W-1:0] err_cnt, err_cnt_n;
    logic             lvl_known, lvl_known_n;
    logic             lvl, lvl_n;
    logic             decode_n, decode_valid_n, cv_err_n, ar_err_n;
    logic [1:0]       parallel_encode_n;

    logic [1:0]       pair;
    logic             is_cv, is_one, is_ar;
    logic [CNT_W-1:0] good_inc, err_inc;

    // Pair classification against the stored first chip and last 1-pair level.
    always_comb begin
        pair     = {first_chip, serial_encode_sig};
        is_cv    = (pair == 2'b10);
        is_one   = (pair[1] == pair[0]);
        is_ar    = is_one && lvl_known && (lvl == pair[0]);
        good_inc = (good_cnt == CNT_W'(CNT_MAX)) ? good_cnt : good_cnt + CNT_W'(1);
        err_inc  = (err_cnt == CNT_W'(CNT_MAX)) ? err_cnt : err_cnt + CNT_W'(1);
    end

    // Next-state and registered-output logic; pulses default low, everything else holds.
    always_comb begin
        state_n           = state;
        phase_n           = phase;
        first_chip_n      = first_chip;
        good_cnt_n        = good_cnt;
        err_cnt_n         = err_cnt;
        lvl_known_n       = lvl_known;
        lvl_n             = lvl;
        decode_n          = decode_sig;
        decode_valid_n    = 1'b0;
        cv_err_n          = 1'b0;
        ar_err_n          = 1'b0;
        parallel_encode_n = parallel_encode_sig;

        if (chip_valid_sig) begin
            if (!phase) begin
                first_chip_n = serial_encode_sig;
                phase_n      = 1'b1;
            end else begin
                phase_n           = 1'b0;
                parallel_encode_n = pair;
                cv_err_n          = is_cv;
                ar_err_n          = is_ar && (state != HUNT);
                if (is_one) begin
                    lvl_known_n = 1'b1;
                    lvl_n       = pair[0];
                end

                case (state)
                    HUNT: begin
                        if (is_cv) begin
                            // Slip one chip: the second chip starts the next pair.
                            phase_n      = 1'b1;
                            first_chip_n = serial_encode_sig;
                        end else begin
                            state_n    = CHECK;
                            good_cnt_n = CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        if (is_cv) begin
                            phase_n      = 1'b1;
                            first_chip_n = serial_encode_sig;
                            state_n      = HUNT;
                            lvl_known_n  = 1'b0;
                            good_cnt_n   = '0;
                        end else if (is_ar) begin
                            state_n     = HUNT;
                            lvl_known_n = 1'b0;
                            good_cnt_n  = '0;
                        end else if (good_inc >= CNT_W'(LOCK_CNT)) begin
                            state_n    = LOCK;
                            good_cnt_n = '0;
                            err_cnt_n  = '0;
                        end else begin
                            good_cnt_n = good_inc;
                        end
                    end
                    LOCK: begin
                        decode_valid_n = 1'b1;
                        if (is_cv || is_ar) begin
                            // Code violation reads as 0, alternation error as 1.
                            decode_n   = is_ar;
                            good_cnt_n = '0;
                            err_cnt_n  = err_inc;
                            if (err_inc >= CNT_W'(LOSS_CNT)) begin
                                state_n     = HUNT;
                                lvl_known_n = 1'b0;
                                err_cnt_n   = '0;
                            end
                        end else begin
                            decode_n = is_one;
                            if (good_inc >= CNT_W'(LOCK_CNT)) begin
                                good_cnt_n = '0;
                                err_cnt_n  = '0;
                            end else begin
                                good_cnt_n = good_inc;
                            end
                        end
                    end
                    default: begin
                        state_n = HUNT;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset wins over any chip strobe.
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            state               <= HUNT;
            phase               <= 1'b0;
            first_chip          <= 1'b0;
            good_cnt            <= '0;
            err_cnt             <= '0;
            lvl_known           <= 1'b0;
            lvl                 <= 1'b0;
            decode_sig          <= 1'b0;
            decode_valid_sig    <= 1'b0;
            cv_err_sig          <= 1'b0;
            ar_err_sig          <= 1'b0;
            parallel_encode_sig <= 2'b00;
        end else begin
            state               <= state_n;
            phase               <= phase_n;
            first_chip          <= first_chip_n;
            good_cnt            <= good_cnt_n;
            err_cnt             <= err_cnt_n;
            lvl_known           <= lvl_known_n;
            lvl                 <= lvl_n;
            decode_sig          <= decode_n;
            decode_valid_sig    <= decode_valid_n;
            cv_err_sig          <= cv_err_n;
            ar_err_sig          <= ar_err_n;
            parallel_encode_sig <= parallel_encode_n;
        end
    end

    assign lock_sig = (state == LOCK);

endmodule

// File: tb/tb_cmi_decoder.sv
// tb/tb_cmi_decoder.sv - directed self-checking bench for cmi_decoder
module tb_cmi_decoder;

    logic       clk_sig = 1'b0;
    logic       reset_sig = 1'b1;
    logic       chip_valid_sig = 1'b0;
    logic       serial_encode_sig = 1'b0;
    logic       decode_sig;
    logic       decode_valid_sig;
    logic [1:0] parallel_encode_sig;
    logic       lock_sig;
    logic       cv_err_sig;
    logic       ar_err_sig;

    int   n_vec = 0;
    int   n_err = 0;
    logic tb_lvl = 1'b1;
    logic exp_dec = 1'b0;
    logic [7:0] dat = 8'b0100_1101;

    cmi_decoder #(.LOCK_CNT(8), .LOSS_CNT(4)) dut (
        .clk_sig            (clk_sig),
        .reset_sig          (reset_sig),
        .chip_valid_sig     (chip_valid_sig),
        .serial_encode_sig  (serial_encode_sig),
        .decode_sig         (decode_sig),
        .decode_valid_sig   (decode_valid_sig),
        .parallel_encode_sig(parallel_encode_sig),
        .lock_sig           (lock_sig),
        .cv_err_sig         (cv_err_sig),
        .ar_err_sig         (ar_err_sig)
    );

    always #5 clk_sig = ~clk_sig;

    function automatic logic [6:0] outs();
        return {decode_valid_sig, decode_sig, parallel_encode_sig, lock_sig, cv_err_sig, ar_err_sig};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {dv,dec,pe,lock,cv,ar}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chip(input logic c);
        chip_valid_sig    = 1'b1;
        serial_encode_sig = c;
        @(posedge clk_sig);
        #1;
        chip_valid_sig = 1'b0;
    endtask

    task automatic idle(input string tag, input int gap, input logic [1:0] pe, input logic lk);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_sig);
            #1;
            chk(tag, outs(), {1'b0, exp_dec, pe, lk, 1'b0, 1'b0});
        end
    endtask

    task automatic do_pair(input string tag, input logic [1:0] p, input logic dv, input logic lk,
                           input logic cv, input logic ar, input int gap);
        logic [1:0] pe_before;
        logic       lk_before;
        pe_before = parallel_encode_sig;
        lk_before = lock_sig;
        chip(p[1]);
        chk({tag, "_mid"}, {decode_valid_sig, cv_err_sig, ar_err_sig}, 3'b000);
        idle({tag, "_gap1"}, gap, pe_before, lk_before);
        chip(p[0]);
        if (dv) exp_dec = (p == 2'b10) ? 1'b0 : (p[1] == p[0]);
        chk(tag, outs(), {dv, exp_dec, p, lk, cv, ar});
        idle({tag, "_gap2"}, gap, p, lk);
    endtask

    task automatic send_bit(input string tag, input logic b, input logic dv, input logic lk, input int gap);
        logic [1:0] p;
        if (b) begin
            tb_lvl = ~tb_lvl;
            p = {tb_lvl, tb_lvl};
        end else begin
            p = 2'b01;
        end
        do_pair(tag, p, dv, lk, 1'b0, 1'b0, gap);
    endtask

    task automatic do_reset();
        reset_sig      = 1'b1;
        chip_valid_sig = 1'b0;
        repeat (2) @(posedge clk_sig);
        #1;
        chk("reset", outs(), 7'b0);
        reset_sig = 1'b0;
        tb_lvl    = 1'b1;
        exp_dec   = 1'b0;
    endtask

    // Directed sequence: lock, alternation error, loss of lock, offset stream, slow strobe, mid-pair reset.
    initial begin
        do_reset();

        // Aligned stream locks on the 8th pair, which itself is not decoded.
        for (int i = 0; i < 8; i++) send_bit("acq", dat[i], 1'b0, (i == 7), 0);
        for (int i = 0; i < 8; i++) send_bit("data", dat[7-i], 1'b1, 1'b1, 0);

        // Repeated 1-pair level: alternation error while staying locked.
        do_pair("ar", {tb_lvl, tb_lvl}, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 8; i++) send_bit("ar_clr", dat[i], 1'b1, 1'b1, 0);

        // Error count was cleared, so only the 4th of these violations drops lock.
        for (int k = 0; k < 4; k++) begin
            do_pair("cv_lock", 2'b10, 1'b1, (k < 3), 1'b1, 1'b0, 0);
            if (k < 3) begin
                send_bit("cv_good", 1'b1, 1'b1, 1'b1, 0);
                send_bit("cv_good", 1'b0, 1'b1, 1'b1, 0);
            end
        end
        send_bit("hunt_after_loss", 1'b1, 1'b0, 1'b0, 0);

        // Stream offset by one chip: violation in HUNT, slip, then lock after 8 pairs.
        do_reset();
        chip(1'b1);
        chk("off_first", outs(), 7'b0);
        chip(1'b0);
        chk("off_cv", outs(), {1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0});
        tb_lvl = ~tb_lvl;
        chip(1'b0);
        chk("off_slip", outs(), {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        for (int i = 1; i < 8; i++) send_bit("off_acq", dat[i], 1'b0, (i == 7), 0);
        for (int i = 0; i < 4; i++) send_bit("off_data", dat[i], 1'b1, 1'b1, 0);

        // Strobe every third cycle; outputs hold on idle cycles.
        do_reset();
        for (int i = 0; i < 8; i++) send_bit("slow_acq", dat[i], 1'b0, (i == 7), 2);
        for (int i = 0; i < 6; i++) send_bit("slow_data", dat[7-i], 1'b1, 1'b1, 2);

        // Reset mid-pair while locked, with a strobe present, then re-lock in exactly 8 pairs.
        send_bit("pre_rst", 1'b1, 1'b1, 1'b1, 0);
        chip(1'b0);
        chip_valid_sig    = 1'b1;
        serial_encode_sig = 1'b1;
        reset_sig         = 1'b1;
        @(posedge clk_sig);
        #1;
        reset_sig      = 1'b0;
        chip_valid_sig = 1'b0;
        chk("mid_rst", outs(), 7'b0);
        tb_lvl  = 1'b1;
        exp_dec = 1'b0;
        for (int i = 0; i < 8; i++) send_bit("relock", dat[i], 1'b0, (i == 7), 0);
        for (int i = 0; i < 3; i++) send_bit("relock_data", dat[i], 1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmi_decoder.md
CMI_DECODER -- requirements
Module: cmi_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive good chip pairs needed to declare lock and to clear the in-lock error count.
REQ-002 Parameter LOSS_CNT, default 4: accumulated in-lock errors that force loss of lock.
REQ-003 clk_sig  input  1  single clock for the block; every register is clocked on its rising edge.
REQ-004 reset_sig  input  1  reset, synchronous and active-high.
REQ-005 chip_valid_sig  input  1  qualifies serial_encode_sig for this cycle, at one CMI chip per strobe.
REQ-006 serial_encode_sig  input  1  serial CMI chip stream, first chip of each bit first.
REQ-007 decode_sig  output  1  recovered NRZ data bit.
REQ-008 decode_valid_sig  output  1  one-cycle pulse qualifying decode_sig.
REQ-009 parallel_encode_sig  output  2  last aligned chip pair {first,second}, updated with each pair.
REQ-010 lock_sig  output  1  high while in state LOCK.
REQ-011 cv_err_sig  output  1  one-cycle pulse on a code violation (pair 10).
REQ-012 ar_err_sig  output  1  one-cycle pulse on an alternation error (two consecutive 1-pairs with the same level).

Function
REQ-013 Decoder shall hold all state when chip_valid_sig is low; chips are accepted only on cycles with chip_valid_sig high.
REQ-014 Internal phase bit shall toggle on each accepted chip; phase 0 chip is stored as first, phase 1 chip completes a pair.
REQ-015 Pair decode shall be: 01 -> 0; 00 or 11 -> 1; 10 -> code violation.
REQ-016 Alternation shall track the level of the last 1-pair; a 1-pair at the same level as the previous 1-pair is an alternation error; the level is unknown after reset or on entry to HUNT, and the first 1-pair sets it without error.
REQ-017 All pair-derived outputs shall be registered and appear on the clock edge after the cycle that accepted the second chip (1-cycle latency).
REQ-018 FSM states shall be HUNT, CHECK and LOCK, with good_cnt and err_cnt counters each sized to hold LOCK_CNT.
REQ-019 In HUNT, on pair 10: slip by one chip (the second chip becomes the first chip of the next pair, phase stays 1), cv_err_sig pulses, and no decode_valid_sig.
REQ-020 In HUNT, on a legal pair: go to CHECK with good_cnt=1.
REQ-021 In CHECK, on a legal pair with no alternation error: good_cnt increments; when it reaches LOCK_CNT, go to LOCK with good_cnt=0 and err_cnt=0.
REQ-022 In CHECK, on pair 10: slip as in REQ-019 and go to HUNT.
REQ-023 In CHECK, on an alternation error: go to HUNT without slip.
REQ-024 decode_valid_sig shall pulse only for pairs completed while in LOCK, including error pairs.
REQ-025 In LOCK, on pair 10: decode_sig=0, cv_err_sig pulses, err_cnt increments, good_cnt clears, and no slip.
REQ-026 In LOCK, on an alternation error: decode_sig=1, ar_err_sig pulses, err_cnt increments, good_cnt clears.
REQ-027 In LOCK, on a good pair: good_cnt increments; at LOCK_CNT, err_cnt and good_cnt clear together.
REQ-028 In LOCK, when err_cnt reaches LOSS_CNT: go to HUNT on that same update; lock_sig falls on the same edge as the final error pulse.
REQ-029 Counters shall saturate and never wrap.
REQ-030 The pair that completes the lock shall not itself produce decode_valid_sig; the first decode_valid_sig comes from the next pair.
REQ-031 parallel_encode_sig shall update for every completed pair in every state.

Reset
REQ-032 reset_sig high at a clock edge shall override chip_valid_sig.
REQ-033 On reset, outputs shall be: decode_sig=0, decode_valid_sig=0, parallel_encode_sig=00, lock_sig=0, cv_err_sig=0, ar_err_sig=0.
REQ-034 On reset, internal state shall be: FSM=HUNT, phase=0, counters=0, alternation level unknown.
REQ-035 Reset asserted mid-pair shall discard the stored first chip.

Verification
REQ-036 Aligned stream for data 1,0,1,1,0,... (chips 00,01,11,00,01,...), strobe every cycle -> lock_sig rises after 8 good pairs; afterwards decode_valid_sig pulses every second cycle and decode_sig reproduces the data with 1-cycle latency.
REQ-037 Same stream offset by one chip -> one cv_err_sig pulse in HUNT, then a slip, then lock within 8 further pairs; data is correct after lock.
REQ-038 While locked, inject 4 pairs of 10 spaced by fewer than 8 good pairs -> 4 cv_err_sig pulses, each with decode_sig=0; lock_sig falls with the 4th.
REQ-039 While locked, inject pair 00 following a previous 1-pair of 00 -> ar_err_sig pulses, decode_sig=1, lock_sig stays high; after 8 good pairs err_cnt returns to 0.
REQ-040 Strobe chip_valid_sig every 3rd cycle -> identical decoded sequence; no output changes on non-strobe cycles.
REQ-041 Assert reset_sig for 1 cycle mid-pair while locked -> all outputs 0 on the next edge; re-lock takes exactly 8 pairs.
